// File: rtl/dot_seq_ctrl_pkg.sv
// Shared definitions for the dot-product sequencer: lane geometry,
// default widths, FSM state encoding and the tail-mask decode.
package dot_seq_ctrl_pkg;

    localparam int LANES         = 4;
    localparam int LANE_W        = 8;
    localparam int WIDTH_SUM_DEF = 32;
    localparam int LEN_W_DEF     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Lanes that carry real elements on the final beat, given len mod 4.
    function automatic logic [LANES-1:0] tail_mask(input logic [1:0] tail);
        logic [LANES-1:0] m;
        case (tail)
            2'd1:    m = 4'b0001;
            2'd2:    m = 4'b0011;
            2'd3:    m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dot_seq_ctrl_if.sv
// Job, operand, MAC and result signals of the dot-product sequencer.
// slave: the sequencer itself; master: front end + MAC side.
interface dot_seq_ctrl_if
    import dot_seq_ctrl_pkg::*;
#(
    parameter int WIDTH_SUM = WIDTH_SUM_DEF,
    parameter int LEN_W     = LEN_W_DEF
) ();

    logic                    start;
    logic [LEN_W-1:0]        len;
    logic [WIDTH_SUM-1:0]    bias;
    logic                    busy;

    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*LANE_W-1:0] in_a;
    logic [LANES*LANE_W-1:0] in_b;

    logic [LANES-1:0]        mac_valid;
    logic [LANES*LANE_W-1:0] mac_a;
    logic [LANES*LANE_W-1:0] mac_b;
    logic [WIDTH_SUM-1:0]    mac_sumin;
    logic [WIDTH_SUM-1:0]    mac_out;

    logic                    res_valid;
    logic                    res_ready;
    logic [WIDTH_SUM-1:0]    res_data;

    modport slave (
        input  start, len, bias, in_valid, in_a, in_b, mac_out, res_ready,
        output busy, in_ready, mac_valid, mac_a, mac_b, mac_sumin,
               res_valid, res_data
    );

    modport master (
        output start, len, bias, in_valid, in_a, in_b, mac_out, res_ready,
        input  busy, in_ready, mac_valid, mac_a, mac_b, mac_sumin,
               res_valid, res_data
    );

endinterface

// File: rtl/dot_seq_ctrl_mask.sv
// Per-lane enable generator for the MAC: all lanes on every beat except
// the last, where only the lanes holding real elements stay enabled.
module dot_seq_mask
    import dot_seq_ctrl_pkg::*;
(
    input  logic             last,
    input  logic [1:0]       tail,
    output logic [LANES-1:0] mask
);

    // Trim upper lanes only on the final beat.
    always_comb begin
        mask = '1;
        if (last) begin
            mask = tail_mask(tail);
        end
    end

endmodule

// File: rtl/dot_seq_ctrl.sv
// Dot-product sequencer: takes a job (len, bias), streams packed int8
// operand beats through an external combinational MAC, keeps the running
// sum in acc and hands back the result with a valid/ready handshake.
// Optional build macro DOT_SEQ_RELU_EN clamps negative results to zero at
// the output only.
//
// state | meaning
// IDLE  | waiting for start; len/bias sampled here
// RUN   | accepting operand beats, beats counts down to the last one
// DONE  | result held on res_data until res_ready
module dot_seq_ctrl
    import dot_seq_ctrl_pkg::*;
#(
    parameter int WIDTH_SUM = WIDTH_SUM_DEF,
    parameter int LEN_W     = LEN_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    dot_seq_ctrl_if.slave  bus
);

    state_t               state, state_nx;
    logic [WIDTH_SUM-1:0] acc, acc_nx;
    logic [LEN_W-1:0]     beats, beats_nx;
    logic [1:0]           tail, tail_nx;

    logic [LEN_W:0]       len_p3;
    logic [LEN_W-1:0]     beats_init;
    logic                 last_beat;
    logic [LANES-1:0]     lane_mask;
    logic [WIDTH_SUM-1:0] res_val;

    // One extra bit so len near full scale cannot wrap before the divide.
    assign len_p3     = {1'b0, bus.len} + (LEN_W+1)'(3);
    assign beats_init = LEN_W'(len_p3 >> 2);
    assign last_beat  = (beats == LEN_W'(1));

    dot_seq_mask u_mask (
        .last (last_beat),
        .tail (tail),
        .mask (lane_mask)
    );

    // State, accumulator, beat down-counter and tail registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            beats <= '0;
            tail  <= '0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            beats <= beats_nx;
            tail  <= tail_nx;
        end
    end

    // Next-state and datapath update decode.
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        beats_nx = beats;
        tail_nx  = tail;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_nx = bus.bias;
                    if (bus.len != '0) begin
                        beats_nx = beats_init;
                        tail_nx  = bus.len[1:0];
                        state_nx = RUN;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            RUN: begin
                if (bus.in_valid) begin
                    acc_nx   = bus.mac_out;
                    beats_nx = beats - LEN_W'(1);
                    if (last_beat) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef DOT_SEQ_RELU_EN
    assign res_val = acc[WIDTH_SUM-1] ? '0 : acc;
`else
    assign res_val = acc;
`endif

    // Outputs decode from the state register only, never from in_valid.
    assign bus.busy      = (state == RUN) || (state == DONE);
    assign bus.in_ready  = (state == RUN);
    assign bus.res_valid = (state == DONE);
    assign bus.res_data  = (state == DONE) ? res_val : '0;
    assign bus.mac_valid = (state == RUN) ? lane_mask : '0;
    assign bus.mac_a     = bus.in_a;
    assign bus.mac_b     = bus.in_b;
    assign bus.mac_sumin = acc;

endmodule

// File: doc/dot_seq_ctrl.md
# dot_seq_ctrl

Sequencer that drives the four-lane int8 MAC datapath to compute a full signed dot product of length `len` over a stream of packed 32-bit operand words. It accepts a job (length plus bias), accepts operand beats with a valid/ready handshake, and feeds the running accumulator back as the MAC's `sumin`. It generates the per-lane valid mask for the tail beat and returns the 32-bit result with a valid/ready handshake. It sits between the accelerator's register/DMA front end and the combinational MAC.

## Interface
- `WIDTH_SUM`, 32: accumulator and result width.
- `LEN_W`, 16: width of the element-count field.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: job request, sampled only in IDLE.
- `len` in LEN_W: number of int8 elements, sampled with `start`.
- `bias` in WIDTH_SUM: signed initial accumulator value, sampled with `start`.
- `busy` out 1: high in RUN and DONE.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: operand beat accepted when `in_valid & in_ready`.
- `in_a`, `in_b` in 32: four packed signed int8 lanes each; lane k is bits [8k+7:8k].
- `mac_valid` out 4: lane enables to the MAC.
- `mac_a`, `mac_b` out 32: pass-through of `in_a` and `in_b`.
- `mac_sumin` out WIDTH_SUM: current accumulator.
- `mac_out` in WIDTH_SUM: MAC result, combinational from the `mac_*` outputs.
- `res_valid` out 1: result valid.
- `res_ready` in 1: result consumer ready.
- `res_data` out WIDTH_SUM: final dot product.

## Operation
- FSM states are IDLE, RUN and DONE. On reset the FSM goes to IDLE and acc=0, beats=0, `busy`=0, `in_ready`=0, `res_valid`=0, `res_data`=0, `mac_valid`=0.
- **IDLE**
  - When `start`=1 and `len`≠0: set acc←`bias`, beats←(`len`+3)>>2 (LEN_W-bit result, computed without overflow), latch `tail`←`len[1:0]`, then go to RUN.
  - When `start`=1 and `len`=0: set acc←`bias`, then go to DONE.
- **RUN**
  - `in_ready`=1.
  - Each accepted beat: acc←`mac_out` and beats←beats−1.
  - On the beat where beats=1, go to DONE.
  - A beat with `in_valid`=0 is a stall; state is unchanged.
- **Lane mask**
  - `mac_valid`=4'b1111 on every beat except the last.
  - On the last beat the mask depends on `tail`: 1→0001, 2→0011, 3→0111, 0→1111.
  - `mac_valid`=0 outside RUN.
- **DONE**
  - `res_valid`=1 and `res_data`=acc, both held stable until `res_ready`=1.
  - On the cycle `res_valid & res_ready`, go to IDLE.
- **Ignored inputs**
  - `start` is ignored in RUN and DONE.
  - `in_valid` is ignored outside RUN.
- **Arithmetic**
  - Accumulation is two's-complement modulo 2^WIDTH_SUM, with no saturation.
  - Masked lanes contribute 0; that masking is the MAC's responsibility.
- **Reset mid-job**: all state returns to the reset values immediately and the partial result is discarded.

## Timing
- The accumulator register updates on the edge that accepts a beat; the MAC path is purely combinational within that cycle.
- `res_valid` rises on the cycle after the last beat is accepted.
- Minimum job latency, measured from `start` to `res_valid` with no stalls, is ceil(`len`/4)+1 cycles.
- With `len`=0, `res_valid` rises 1 cycle after `start`.
- The earliest next `start` is accepted in the cycle after the result handshake, giving one IDLE bubble.
- `in_ready` is a registered function of state only and never depends on `in_valid`.

## Configuration
- `DOT_SEQ_RELU_EN`
  - Defined: `res_data` = 0 when acc is negative (acc[WIDTH_SUM-1]=1), otherwise acc. The clamp applies only at output; accumulation is unaffected.
  - Undefined: `res_data` = acc unchanged.

## Structure
- The shared package holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - `LANES`=4 and `LANE_W`=8;
  - the default `WIDTH_SUM`.
- One sub-module, `dot_seq_mask`: combinational tail-mask generator with inputs `last` and `tail[1:0]` and output `mask[3:0]`.
- The MAC is instantiated outside this block; the bench ties `mac_out` to a MAC model.

## Test plan
- `len`=4, `bias`=0, one beat `in_a`=32'h04030201, `in_b`=32'h01010101 -> `mac_valid`=1111; `res_data`=10 two cycles after `start`.
- `len`=6, `bias`=5, beats (32'h01010101, 32'h01010101) then (32'hFFFF0202, 32'h01010303) -> second beat has `mac_valid`=0011; `res_data`=5+4+12=21.
- `len`=0, `bias`=-7 -> `res_valid` 1 cycle after `start`; `res_data`=32'hFFFFFFF9 without `DOT_SEQ_RELU_EN`, 0 with it.
- `len`=8 with `in_valid` gapped every other cycle, and `res_ready` held low 5 cycles -> result correct; `res_data` stable while stalled; `start` pulses during RUN and DONE ignored.
- Assert `rst` after the 2nd of 4 beats -> next cycle all outputs at reset values; a new job (`len`=4) yields only its own result.
- Lanes all -128×127 over `len`=4, `bias`=0 -> acc = −65024; RELU build outputs 0, default build outputs 32'hFFFF0200.
